// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multiported architectural register file with a
// per-register busy scoreboard and a post-reset zero-scrub FSM.
module rf_mp_sb #(
    parameter  int DATA_LEN      = 32,
    parameter  int NUM_REGS      = 32,
    parameter  int NUM_W_PORTS   = 2,
    parameter  int NUM_R_PORTS   = 4,
    parameter  int NUM_SET_PORTS = 2,
    localparam int ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_W_PORTS-1:0]                   w_val,
    input  logic [NUM_W_PORTS-1:0][ADDR_W-1:0]       w_addr,
    input  logic [NUM_W_PORTS-1:0][DATA_LEN-1:0]     w_data,
    input  logic [NUM_R_PORTS-1:0]                   r_val,
    input  logic [NUM_R_PORTS-1:0][ADDR_W-1:0]       r_addr,
    output logic [NUM_R_PORTS-1:0][DATA_LEN-1:0]     r_data,
    output logic [NUM_R_PORTS-1:0]                   r_data_val,
    output logic [NUM_R_PORTS-1:0]                   r_busy,
    input  logic [NUM_SET_PORTS-1:0]                 set_val,
    input  logic [NUM_SET_PORTS-1:0][ADDR_W-1:0]     set_addr,
    output logic                                     init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q;
    logic [DATA_LEN-1:0]      regs_q [NUM_REGS];
    logic [DATA_LEN-1:0]      regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_REGS-1:0]      hit, set_hit;
    logic [NUM_R_PORTS-1:0][DATA_LEN-1:0] rd_d;
    logic [NUM_R_PORTS-1:0]   rb_d;
    logic                     run;

    assign run = (state_q == S_RUN);

    // FSM state and scrub pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) ptr_q <= ptr_q + 1'b1;
        end
    end

    // leave INIT once the last register has been scrubbed
    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && ptr_q == ADDR_W'(NUM_REGS - 1))
            state_d = S_RUN;
    end

    // scrub completion flag follows the terminal state
    always_comb begin
        init_done = run;
    end

    // next array contents and write/set hit vectors;
    // later write ports override earlier ones
    always_comb begin
        hit     = '0;
        set_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!run && ptr_q == ADDR_W'(i)) regs_d[i] = '0;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int w = 0; w < NUM_W_PORTS; w++) begin
                if (run && w_val[w] && w_addr[w] == ADDR_W'(i)) begin
                    regs_d[i] = w_data[w];
                    hit[i]    = 1'b1;
                end
            end
            for (int s = 0; s < NUM_SET_PORTS; s++) begin
                if (run && set_val[s] && set_addr[s] == ADDR_W'(i))
                    set_hit[i] = 1'b1;
            end
        end
    end

    // a set in the same cycle as a write-clear leaves the bit busy
    always_comb begin
        busy_d = (busy_q & ~hit) | set_hit;
    end

    // register array; contents come from the scrub, not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end

    // scoreboard bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    // read mux with write bypass; x0 and out-of-range read as zero
    always_comb begin
        for (int r = 0; r < NUM_R_PORTS; r++) begin
            rd_d[r] = '0;
            rb_d[r] = 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (r_addr[r] == ADDR_W'(i)) begin
                    rd_d[r] = regs_d[i];
                    rb_d[r] = busy_q[i] & ~hit[i];
                end
            end
        end
    end

    // registered read outputs; idle ports hold their last value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data     <= '0;
            r_busy     <= '0;
            r_data_val <= '0;
        end else begin
            r_data_val <= run ? r_val : '0;
            for (int r = 0; r < NUM_R_PORTS; r++) begin
                if (run && r_val[r]) begin
                    r_data[r] <= rd_d[r];
                    r_busy[r] <= rb_d[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_mp_sb.sv
// tb_rf_mp_sb: directed and randomized checks of rf_mp_sb
// on a 32-reg/4R instance and a 48-reg/6R instance.
module tb_rf_mp_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0]        a_w_val;
    logic [1:0][4:0]   a_w_addr;
    logic [1:0][31:0]  a_w_data;
    logic [3:0]        a_r_val;
    logic [3:0][4:0]   a_r_addr;
    logic [3:0][31:0]  a_r_data;
    logic [3:0]        a_r_data_val;
    logic [3:0]        a_r_busy;
    logic [1:0]        a_set_val;
    logic [1:0][4:0]   a_set_addr;
    logic              a_init_done;

    logic [1:0]        b_w_val;
    logic [1:0][5:0]   b_w_addr;
    logic [1:0][31:0]  b_w_data;
    logic [5:0]        b_r_val;
    logic [5:0][5:0]   b_r_addr;
    logic [5:0][31:0]  b_r_data;
    logic [5:0]        b_r_data_val;
    logic [5:0]        b_r_busy;
    logic [1:0]        b_set_val;
    logic [1:0][5:0]   b_set_addr;
    logic              b_init_done;

    rf_mp_sb u_a (
        .clk(clk), .rst(rst),
        .w_val(a_w_val), .w_addr(a_w_addr), .w_data(a_w_data),
        .r_val(a_r_val), .r_addr(a_r_addr), .r_data(a_r_data),
        .r_data_val(a_r_data_val), .r_busy(a_r_busy),
        .set_val(a_set_val), .set_addr(a_set_addr),
        .init_done(a_init_done)
    );

    rf_mp_sb #(.NUM_REGS(48), .NUM_R_PORTS(6)) u_b (
        .clk(clk), .rst(rst),
        .w_val(b_w_val), .w_addr(b_w_addr), .w_data(b_w_data),
        .r_val(b_r_val), .r_addr(b_r_addr), .r_data(b_r_data),
        .r_data_val(b_r_data_val), .r_busy(b_r_busy),
        .set_val(b_set_val), .set_addr(b_set_addr),
        .init_done(b_init_done)
    );

    // reference model state
    logic [31:0] m_reg  [2][64];
    bit          m_busy [2][64];
    logic [31:0] e_rd   [2][6];
    bit          e_rv   [2][6];
    bit          e_rb   [2][6];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        a_w_val = '0; a_w_addr = '0; a_w_data = '0;
        a_r_val = '0; a_r_addr = '0;
        a_set_val = '0; a_set_addr = '0;
        b_w_val = '0; b_w_addr = '0; b_w_data = '0;
        b_r_val = '0; b_r_addr = '0;
        b_set_val = '0; b_set_addr = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 64; a++) begin
                m_reg[i][a]  = '0;
                m_busy[i][a] = 1'b0;
            end
            for (int r = 0; r < 6; r++) begin
                e_rd[i][r] = '0;
                e_rv[i][r] = 1'b0;
                e_rb[i][r] = 1'b0;
            end
        end
    endtask

    function automatic int rnd_addr(input int amax);
        if ($urandom_range(0, 2) == 0) return $urandom_range(0, amax);
        return $urandom_range(0, 7);
    endfunction

    task automatic check_inst(input int i);
        int nr = (i == 0) ? 4 : 6;
        for (int r = 0; r < nr; r++) begin
            logic [31:0] od;
            logic ov, ob;
            if (i == 0) begin
                od = a_r_data[r]; ov = a_r_data_val[r]; ob = a_r_busy[r];
            end else begin
                od = b_r_data[r]; ov = b_r_data_val[r]; ob = b_r_busy[r];
            end
            chk($sformatf("i%0d_p%0d_val", i, r), ov, e_rv[i][r]);
            chk($sformatf("i%0d_p%0d_data", i, r), od, e_rd[i][r]);
            chk($sformatf("i%0d_p%0d_busy", i, r), ob, e_rb[i][r]);
        end
    endtask

    // draw one cycle of traffic for instance i and advance the model
    task automatic gen_and_model(input int i);
        int nr   = (i == 0) ? 4 : 6;
        int nreg = (i == 0) ? 32 : 48;
        int amax = (i == 0) ? 31 : 63;
        bit          gwv [2];
        int          gwa [2];
        logic [31:0] gwd [2];
        bit          grv [6];
        int          gra [6];
        bit          gsv [2];
        int          gsa [2];
        bit          wr  [64];
        for (int w = 0; w < 2; w++) begin
            gwv[w] = ($urandom_range(0, 1) == 1);
            gwa[w] = rnd_addr(amax);
            gwd[w] = $urandom;
            gsv[w] = ($urandom_range(0, 3) == 0);
            gsa[w] = rnd_addr(amax);
        end
        for (int r = 0; r < 6; r++) begin
            grv[r] = ($urandom_range(0, 2) != 0);
            gra[r] = rnd_addr(amax);
        end
        if (i == 0) begin
            for (int w = 0; w < 2; w++) begin
                a_w_val[w]    = gwv[w];
                a_w_addr[w]   = gwa[w][4:0];
                a_w_data[w]   = gwd[w];
                a_set_val[w]  = gsv[w];
                a_set_addr[w] = gsa[w][4:0];
            end
            for (int r = 0; r < 4; r++) begin
                a_r_val[r]  = grv[r];
                a_r_addr[r] = gra[r][4:0];
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                b_w_val[w]    = gwv[w];
                b_w_addr[w]   = gwa[w][5:0];
                b_w_data[w]   = gwd[w];
                b_set_val[w]  = gsv[w];
                b_set_addr[w] = gsa[w][5:0];
            end
            for (int r = 0; r < 6; r++) begin
                b_r_val[r]  = grv[r];
                b_r_addr[r] = gra[r][5:0];
            end
        end
        for (int a = 0; a < 64; a++) wr[a] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (gwv[w] && gwa[w] != 0 && gwa[w] < nreg) begin
                m_reg[i][gwa[w]] = gwd[w];
                wr[gwa[w]] = 1'b1;
            end
        end
        for (int r = 0; r < nr; r++) begin
            e_rv[i][r] = grv[r];
            if (grv[r]) begin
                if (gra[r] != 0 && gra[r] < nreg) begin
                    e_rd[i][r] = m_reg[i][gra[r]];
                    e_rb[i][r] = m_busy[i][gra[r]] && !wr[gra[r]];
                end else begin
                    e_rd[i][r] = '0;
                    e_rb[i][r] = 1'b0;
                end
            end
        end
        for (int a = 0; a < 64; a++) if (wr[a]) m_busy[i][a] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (gsv[s] && gsa[s] != 0 && gsa[s] < nreg)
                m_busy[i][gsa[s]] = 1'b1;
        end
    endtask

    initial begin
        idle_all();
        rst = 1'b0;
        repeat (3) step();
        chk("rst_val", a_r_data_val, 4'h0);
        chk("rst_busy", a_r_busy, 4'h0);
        chk("rst_data0", a_r_data[0], 32'h0);
        chk("rst_done", a_init_done, 1'b0);

        // release reset and poll r5 through the scrub
        rst = 1'b1;
        a_r_val = 4'b0001;
        a_r_addr[0] = 5'd5;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("init_val_c%0d", k), a_r_data_val, 4'h0);
            chk($sformatf("init_done_c%0d", k), a_init_done, k == 32);
        end
        step();
        chk("init_rd_val", a_r_data_val, 4'b0001);
        chk("init_rd_r5", a_r_data[0], 32'h0);

        // same-address write conflict: port 1 wins
        a_r_val = '0;
        a_w_val = 2'b11;
        a_w_addr[0] = 5'd7; a_w_data[0] = 32'hAAAA;
        a_w_addr[1] = 5'd7; a_w_data[1] = 32'hBBBB;
        step();
        a_w_val = '0;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd7;
        step();
        chk("conf_r7", a_r_data[0], 32'hBBBB);

        // distinct addresses commit together
        a_r_val = '0;
        a_w_val = 2'b11;
        a_w_addr[0] = 5'd3; a_w_data[0] = 32'h3333;
        a_w_addr[1] = 5'd4; a_w_data[1] = 32'h4444;
        step();
        a_w_val = '0;
        a_r_val = 4'b0011;
        a_r_addr[0] = 5'd3; a_r_addr[1] = 5'd4;
        step();
        chk("dual_r3", a_r_data[0], 32'h3333);
        chk("dual_r4", a_r_data[1], 32'h4444);

        // same-cycle write bypass to all four read ports
        a_w_val = 2'b01;
        a_w_addr[0] = 5'd9; a_w_data[0] = 32'h1234;
        a_r_val = 4'hF;
        for (int r = 0; r < 4; r++) a_r_addr[r] = 5'd9;
        step();
        a_w_val = '0;
        a_r_val = '0;
        chk("byp_val", a_r_data_val, 4'hF);
        for (int r = 0; r < 4; r++)
            chk($sformatf("byp_p%0d", r), a_r_data[r], 32'h1234);

        // x0 ignores writes, both bypassed and later
        a_w_val = 2'b01;
        a_w_addr[0] = 5'd0; a_w_data[0] = 32'hFFFF;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd0;
        step();
        a_w_val = '0;
        chk("x0_byp", a_r_data[0], 32'h0);
        step();
        chk("x0_rd", a_r_data[0], 32'h0);

        // scoreboard: set, set-vs-clear collision, clear
        a_r_val = '0;
        a_set_val = 2'b01; a_set_addr[0] = 5'd12;
        step();
        a_set_val = '0;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd12;
        step();
        chk("sb_set", a_r_busy[0], 1'b1);
        a_r_val = '0;
        a_w_val = 2'b01;
        a_w_addr[0] = 5'd12; a_w_data[0] = 32'h77;
        a_set_val = 2'b10; a_set_addr[1] = 5'd12;
        step();
        a_w_val = '0;
        a_set_val = '0;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd12;
        step();
        chk("sb_coll_busy", a_r_busy[0], 1'b1);
        chk("sb_coll_data", a_r_data[0], 32'h77);
        a_w_val = 2'b10;
        a_w_addr[1] = 5'd12; a_w_data[1] = 32'h88;
        step();
        a_w_val = '0;
        chk("sb_clr_same_busy", a_r_busy[0], 1'b0);
        chk("sb_clr_same_data", a_r_data[0], 32'h88);
        step();
        chk("sb_clr_busy", a_r_busy[0], 1'b0);

        // idle read port holds data, drops valid
        a_r_val = '0;
        step();
        chk("hold_val", a_r_data_val, 4'h0);
        chk("hold_data", a_r_data[0], 32'h88);

        // register 0 can never become busy
        a_set_val = 2'b01; a_set_addr[0] = 5'd0;
        step();
        a_set_val = '0;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd0;
        step();
        chk("x0_busy", a_r_busy[0], 1'b0);
        a_r_val = '0;

        // reset mid-scrub, with writes attempted during INIT
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (10) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        a_w_val = 2'b01;
        a_w_addr[0] = 5'd4; a_w_data[0] = 32'h55;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("mid_done_c%0d", k), a_init_done, k == 32);
        end
        a_w_val = '0;
        a_r_val = 4'b0001; a_r_addr[0] = 5'd4;
        step();
        chk("mid_r4", a_r_data[0], 32'h0);
        chk("mid_r4_val", a_r_data_val, 4'b0001);

        // randomized traffic on both instances against the model
        idle_all();
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 200 && !(a_init_done && b_init_done); k++)
            step();
        chk("rand_init_a", a_init_done, 1'b1);
        chk("rand_init_b", b_init_done, 1'b1);
        for (int n = 0; n < 400; n++) begin
            check_inst(0);
            check_inst(1);
            gen_and_model(0);
            gen_and_model(1);
            step();
        end
        check_inst(0);
        check_inst(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
